// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clk_div_bank divider family.
package clk_div_pkg;

  localparam int unsigned DIV_MIN = 2;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [31:0] ceil_half(input logic [31:0] n);
    return (n >> 1) + {31'b0, n[0]};
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Control/status bundle for clk_div_bank: ratio write port, enables, SYNC and divided outputs.
interface clk_div_bank_if import clk_div_pkg::*; #(
  parameter int NUM_CH    = 2,
  parameter int CTR_WIDTH = 16,
  parameter int CH_IDX_W  = ch_idx_w(NUM_CH)
) ();

  logic                 WR_EN;
  logic [CH_IDX_W-1:0]  WR_CH;
  logic [CTR_WIDTH-1:0] WR_DIV;
  logic [NUM_CH-1:0]    CH_EN;
  logic                 SYNC;
  logic [NUM_CH-1:0]    CLK_OUT;
  logic [NUM_CH-1:0]    TICK;
  logic [NUM_CH-1:0]    PEND;

  modport master (
    output WR_EN, WR_CH, WR_DIV, CH_EN, SYNC,
    input  CLK_OUT, TICK, PEND
  );

  modport slave (
    input  WR_EN, WR_CH, WR_DIV, CH_EN, SYNC,
    output CLK_OUT, TICK, PEND
  );

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: phase counter, active/shadow ratio and registered CLK_OUT/TICK/PEND.
module clk_div_ch import clk_div_pkg::*; #(
  parameter int CTR_WIDTH = 16,
  parameter int DIV_RST   = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 wr_en,
  input  logic [CTR_WIDTH-1:0] wr_div,
  input  logic                 ch_en,
  input  logic                 sync,
  output logic                 clk_out,
  output logic                 tick,
  output logic                 pend
);

  localparam logic [CTR_WIDTH-1:0] DIV_RST_W = CTR_WIDTH'(DIV_RST);

  function automatic logic [CTR_WIDTH-1:0] clamp_div(input logic [CTR_WIDTH-1:0] n);
    return (n < CTR_WIDTH'(DIV_MIN)) ? CTR_WIDTH'(DIV_MIN) : n;
  endfunction

  logic [CTR_WIDTH-1:0] p_q, p_d;
  logic [CTR_WIDTH-1:0] act_q, act_d;
  logic [CTR_WIDTH-1:0] sh_q, sh_d;
  logic [CTR_WIDTH-1:0] wdiv;
  logic                 pend_q, pend_d;
  logic                 run_q, run_d;
  logic                 clk_q, clk_d;
  logic                 tick_q, tick_d;

  always_comb begin
    p_d    = p_q;
    act_d  = act_q;
    sh_d   = sh_q;
    pend_d = pend_q;
    run_d  = run_q;
    wdiv   = clamp_div(wr_div);

    if (!ch_en) begin
      run_d  = 1'b0;
      p_d    = '0;
      pend_d = 1'b0;
      if (wr_en) begin
        act_d = wdiv;
        sh_d  = wdiv;
      end else if (pend_q) begin
        act_d = sh_q;
      end
    end else if (!run_q) begin
      // Still idle this cycle, so a write lands directly in the first period.
      run_d = 1'b1;
      p_d   = '0;
      if (wr_en) begin
        act_d = wdiv;
        sh_d  = wdiv;
      end
    end else begin
      if (wr_en) sh_d = wdiv;
      if (sync || (p_q == act_q - CTR_WIDTH'(1))) begin
        p_d    = '0;
        pend_d = 1'b0;
        if (wr_en)       act_d = wdiv;
        else if (pend_q) act_d = sh_q;
      end else begin
        p_d = p_q + CTR_WIDTH'(1);
        if (wr_en) pend_d = 1'b1;
      end
    end

    // Outputs are precomputed for the phase that becomes current after the edge.
    clk_d  = run_d && (32'(p_d) < ceil_half(32'(act_d)));
    tick_d = run_d && (p_d == '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      p_q    <= '0;
      act_q  <= DIV_RST_W;
      sh_q   <= DIV_RST_W;
      pend_q <= 1'b0;
      run_q  <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      act_q  <= act_d;
      sh_q   <= sh_d;
      pend_q <= pend_d;
      run_q  <= run_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pend    = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider: write decode plus one clk_div_ch per channel.
module clk_div_bank import clk_div_pkg::*; #(
  parameter int NUM_CH    = 2,
  parameter int CTR_WIDTH = 16,
  parameter int DIV_RST   = 2
) (
  input  logic          CLK,
  input  logic          RST,
  clk_div_bank_if.slave bus
);

  localparam int CH_IDX_W = ch_idx_w(NUM_CH);

  logic [CH_IDX_W-1:0] wr_ch;
  logic                in_range;
  logic [NUM_CH-1:0]   wr_sel;
  logic [NUM_CH-1:0]   clk_out_w;
  logic [NUM_CH-1:0]   tick_w;
  logic [NUM_CH-1:0]   pend_w;

  assign wr_ch = bus.WR_CH;

  // Indices past the last channel are dropped rather than aliased.
  always_comb begin
    in_range = (int'(wr_ch) < NUM_CH);
    wr_sel   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = bus.WR_EN && in_range && (int'(wr_ch) == i);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .CTR_WIDTH (CTR_WIDTH),
      .DIV_RST   (DIV_RST)
    ) u_ch (
      .CLK     (CLK),
      .RST     (RST),
      .wr_en   (wr_sel[g]),
      .wr_div  (bus.WR_DIV),
      .ch_en   (bus.CH_EN[g]),
      .sync    (bus.SYNC),
      .clk_out (clk_out_w[g]),
      .tick    (tick_w[g]),
      .pend    (pend_w[g])
    );
  end

  assign bus.CLK_OUT = clk_out_w;
  assign bus.TICK    = tick_w;
  assign bus.PEND    = pend_w;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: a 2-channel instance plus a 3-channel one for out-of-range writes.
module tb_clk_div_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  clk_div_bank_if #(.NUM_CH(2), .CTR_WIDTH(16)) bus ();
  clk_div_bank_if #(.NUM_CH(3), .CTR_WIDTH(16)) bus3 ();

  clk_div_bank #(.NUM_CH(2), .CTR_WIDTH(16), .DIV_RST(2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  clk_div_bank #(.NUM_CH(3), .CTR_WIDTH(16), .DIV_RST(2)) dut3 (
    .CLK (clk),
    .RST (rst),
    .bus (bus3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called while phase 0 of channel ch is visible; returns at the next phase 0 after reps periods.
  task automatic check_period(input string tag, input int ch, input int n, input int hi, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int k = 0; k < n; k++) begin
        chk({tag, "_clk"}, 32'(bus.CLK_OUT[ch]), 32'(k < hi));
        chk({tag, "_tick"}, 32'(bus.TICK[ch]), 32'(k == 0));
        step();
      end
    end
  endtask

  task automatic wr(input logic [0:0] ch, input logic [15:0] div);
    bus.WR_EN  = 1'b1;
    bus.WR_CH  = ch;
    bus.WR_DIV = div;
  endtask

  initial begin
    bus.WR_EN = 1'b0; bus.WR_CH = '0; bus.WR_DIV = '0; bus.CH_EN = '0; bus.SYNC = 1'b0;
    bus3.WR_EN = 1'b0; bus3.WR_CH = '0; bus3.WR_DIV = '0; bus3.CH_EN = '0; bus3.SYNC = 1'b0;

    step(); step();
    chk("rst_clk", 32'(bus.CLK_OUT), 0);
    chk("rst_tick", 32'(bus.TICK), 0);
    chk("rst_pend", 32'(bus.PEND), 0);
    rst = 1'b0;

    // Default ratio 2 on channel 0
    bus.CH_EN = 2'b01;
    step();
    check_period("t1_n2", 0, 2, 1, 3);
    chk("t1_ch1_clk", 32'(bus.CLK_OUT[1]), 0);
    chk("t1_ch1_tick", 32'(bus.TICK[1]), 0);

    // Idle write to channel 1 applies immediately
    wr(1'b1, 16'd5);
    step();
    bus.WR_EN = 1'b0;
    chk("t2_pend_idle", 32'(bus.PEND[1]), 0);
    bus.CH_EN = 2'b11;
    step();
    check_period("t2_n5", 1, 5, 3, 2);
    chk("t2_pend_run", 32'(bus.PEND[1]), 0);

    // Channel 0 to N=4 via an idle write, then a running write at p=1
    bus.CH_EN = 2'b10;
    wr(1'b0, 16'd4);
    step();
    bus.WR_EN = 1'b0;
    bus.CH_EN = 2'b11;
    step();
    chk("t3_ph0_tick", 32'(bus.TICK[0]), 1);
    step();
    chk("t3_ph1_clk", 32'(bus.CLK_OUT[0]), 1);
    wr(1'b0, 16'd6);
    step();
    bus.WR_EN = 1'b0;
    chk("t3_ph2_pend", 32'(bus.PEND[0]), 1);
    chk("t3_ph2_clk", 32'(bus.CLK_OUT[0]), 0);
    step();
    chk("t3_ph3_pend", 32'(bus.PEND[0]), 1);
    chk("t3_ph3_tick", 32'(bus.TICK[0]), 0);
    step();
    chk("t3_wrap_pend", 32'(bus.PEND[0]), 0);
    check_period("t3_n6", 0, 6, 3, 2);

    // Write at the last phase applies at the immediate wrap
    for (int i = 0; i < 5; i++) step();
    chk("t3b_ph5_tick", 32'(bus.TICK[0]), 0);
    wr(1'b0, 16'd4);
    step();
    bus.WR_EN = 1'b0;
    chk("t3b_pend", 32'(bus.PEND[0]), 0);
    check_period("t3b_n4", 0, 4, 2, 2);

    // Ratios 0 and 1 clamp to 2
    bus.CH_EN = 2'b10;
    wr(1'b0, 16'd0);
    step();
    bus.WR_EN = 1'b0;
    bus.CH_EN = 2'b11;
    step();
    check_period("t4_n0", 0, 2, 1, 2);
    bus.CH_EN = 2'b10;
    wr(1'b0, 16'd1);
    step();
    bus.WR_EN = 1'b0;
    bus.CH_EN = 2'b11;
    step();
    check_period("t4_n1", 0, 2, 1, 2);

    // Out-of-range channel index on the 3-channel instance
    bus3.WR_EN = 1'b1; bus3.WR_CH = 2'd3; bus3.WR_DIV = 16'd5;
    step();
    bus3.WR_EN = 1'b0;
    bus3.CH_EN = 3'b111;
    step();
    chk("t4_oor_clk0", 32'(bus3.CLK_OUT), 7);
    chk("t4_oor_tick0", 32'(bus3.TICK), 7);
    step();
    chk("t4_oor_clk1", 32'(bus3.CLK_OUT), 0);
    chk("t4_oor_tick1", 32'(bus3.TICK), 0);
    step();
    chk("t4_oor_clk2", 32'(bus3.CLK_OUT), 7);
    chk("t4_oor_pend", 32'(bus3.PEND), 0);
    bus3.CH_EN = 3'b000;

    // SYNC realigns both channels; a simultaneous write is live from the resynced period
    wr(1'b0, 16'd4);
    step();
    bus.WR_EN = 1'b0;
    step(); step(); step();
    bus.SYNC = 1'b1;
    wr(1'b1, 16'd7);
    step();
    bus.SYNC = 1'b0;
    bus.WR_EN = 1'b0;
    chk("t5_sync_tick", 32'(bus.TICK), 3);
    chk("t5_sync_clk", 32'(bus.CLK_OUT), 3);
    chk("t5_sync_pend", 32'(bus.PEND), 0);
    check_period("t5_n7", 1, 7, 4, 1);
    bus.SYNC = 1'b1;
    step();
    bus.SYNC = 1'b0;
    check_period("t5_n4", 0, 4, 2, 2);

    // Disable beats SYNC
    bus.SYNC = 1'b1;
    bus.CH_EN = 2'b01;
    step();
    bus.SYNC = 1'b0;
    chk("t5_dis_clk1", 32'(bus.CLK_OUT[1]), 0);
    chk("t5_dis_tick1", 32'(bus.TICK[1]), 0);
    chk("t5_dis_tick0", 32'(bus.TICK[0]), 1);
    step();
    chk("t5_idle_clk1", 32'(bus.CLK_OUT[1]), 0);

    // Reset mid-period with a pending ratio
    wr(1'b0, 16'd6);
    step();
    bus.WR_EN = 1'b0;
    chk("t6_pend_before", 32'(bus.PEND[0]), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_clk", 32'(bus.CLK_OUT), 0);
    chk("t6_rst_tick", 32'(bus.TICK), 0);
    chk("t6_rst_pend", 32'(bus.PEND), 0);
    step();
    check_period("t6_n2", 0, 2, 1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
